// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline stage built as a 2-entry elastic (skid) buffer. All state
// updates happen on the falling edge of clk. Field widths are parameters, so
// the same stage serves scalar and wider-lane datapaths.
//
// Handshake: a transfer happens on a side when valid and ready are both high
// at the falling edge. in_ready comes only from registered state (and rst),
// never from out_ready. Once out_valid is high, the head entry holds stable
// until it is popped, flushed or reset.
//
// Ports:
//   clk, rst            stage clock (falling-edge active), async active-high reset
//   flush               drop every buffered entry and the entry presented this edge
//   in_valid/in_ready   upstream (MEM) handshake
//   wb, muxMem, resALUe, memData, dest, destType    incoming entry fields
//   out_valid/out_ready downstream (writeback) handshake
//   *_out               head entry fields; wb_out is forced to 0 when out_valid=0
//   count               occupancy 0..2, which is also the FSM state encoding
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int VEC_W  = 192,
    parameter int SCAL_W = 21,
    parameter int DEST_W = 3,
    parameter int WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   wb,
    input  logic [VEC_W-1:0]  muxMem,
    input  logic [SCAL_W-1:0] resALUe,
    input  logic [VEC_W-1:0]  memData,
    input  logic [DEST_W-1:0] dest,
    input  logic              destType,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic [VEC_W-1:0]  muxMem_out,
    output logic [SCAL_W-1:0] resALUe_out,
    output logic [VEC_W-1:0]  memData_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              destType_out,
    output logic [1:0]        count
);

    localparam int EW = WB_W + VEC_W + SCAL_W + VEC_W + DEST_W + 1;

    // The state value equals the occupancy, so count exposes the FSM directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [EW-1:0] head;
    logic [EW-1:0] skid;
    logic [EW-1:0] in_data;
    logic          accept;
    logic          pop;

    assign in_data = {wb, muxMem, resALUe, memData, dest, destType};

    assign in_ready  = !rst && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign count     = state;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            // Storage is left as is; out_valid=0 gates wb_out, so nothing
            // stale can be written back.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= in_data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head <= in_data;
                    end else if (accept) begin
                        skid  <= in_data;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    logic [WB_W-1:0] head_wb;

    assign {head_wb, muxMem_out, resALUe_out, memData_out, dest_out, destType_out} = head;
    assign wb_out = out_valid ? head_wb : '0;

endmodule
